lmi_mem_arb: RTL and testbench
==============================

// Module: lmi_mem_arb
// PURPOSE
//  Arbitrates the single external memory port between the I-cache refill engine
//  and the D-cache (refill + write-back).
//  Sequences one transaction at a time: burst line fills (BEATS beats) or single
//  uncached beats.
//  Steers per-beat read data valid (IS_VAL) back to the owning cache.
//  Sits between lmi_icache / lmi_dcache and the external bus interface.
// PARAMETERS
//  BEATS    4   beats per cache line burst; power of two, 2..8
//  CTR_W    2   burst beat counter width = log2(BEATS)
//  MAX_WAIT 255 cycles without MEM_ACK before a timeout error terminates the transaction
// PORTS
//  CLK          in  1   clock
//  RESET_D1_R_N in  1   reset, asynchronous assert, active low
//  IC_REQ       in  1   I-cache request; level, held until IC_DONE
//  IC_ADDR      in  32  I-cache physical address
//  IC_BURST     in  1   1 = line fill, 0 = single uncached read
//  DC_REQ       in  1   D-cache request; level, held until DC_DONE
//  DC_ADDR      in  32  D-cache physical address
//  DC_WR        in  1   1 = write-back/write, 0 = read
//  DC_BURST     in  1   1 = line transfer, 0 = single beat
//  DC_WDATA     in  32  write data for the current beat
//  IC_GNT       out 1   I-cache owns the port
//  DC_GNT       out 1   D-cache owns the port
//  IC_VAL       out 1   read beat valid to I-cache (IS_VAL)
//  DC_VAL       out 1   read beat valid / write beat accepted, to D-cache
//  IC_DONE      out 1   1-cycle pulse: I-cache transaction complete
//  DC_DONE      out 1   1-cycle pulse: D-cache transaction complete
//  BEAT         out 2   index of the current beat (CTR_W bits)
//  ERR          out 1   1-cycle pulse with DONE when the transaction ended on an error
//  MEM_REQ      out 1   address phase valid
//  MEM_ADDR     out 32  line-aligned if burst, else exact word address
//  MEM_WR       out 1   write transaction
//  MEM_BURST    out 1   burst transaction
//  MEM_WDATA    out 32  registered copy of DC_WDATA
//  MEM_AACK     in  1   address phase accepted
//  MEM_ACK      in  1   data beat complete
//  MEM_BERR     in  1   bus error; qualifies MEM_ACK
// BEHAVIOUR
//  Reset values
//   - All outputs 0.
//   - State = IDLE, RR pointer = DC (so I-cache wins the first tie), BEAT = 0,
//     wait counter = 0.
//  States (one-hot): IDLE, ADDR, DATA, DONE.
//  IDLE
//   - If any request: latch winner, ADDR, WR, BURST; assert GNT and MEM_REQ next
//     cycle; go to ADDR. Latency is 1 cycle from REQ to MEM_REQ.
//   - Tie: round-robin. The pointer flips to the loser after each completed
//     transaction. DC_WR=1 beats round-robin only if the same DC line has
//     stalled >= 2 arbitrations.
//  ADDR
//   - Hold MEM_* stable until MEM_AACK.
//   - On MEM_AACK: drop MEM_REQ; go to DATA with BEAT = 0.
//  DATA
//   - Each MEM_ACK: pulse owner VAL for one cycle; BEAT++ (wraps mod BEATS).
//   - Last beat is BEAT==BEATS-1 for burst, BEAT==0 for single; last beat -> DONE.
//   - MEM_BERR with MEM_ACK: set ERR, go to DONE immediately, no VAL.
//   - Wait counter resets on each ACK. Reaching MAX_WAIT acts as BERR.
//  DONE
//   - Pulse owner DONE (+ERR); drop GNT; update pointer; go to IDLE.
//   - A new grant is possible on the following cycle (2-cycle turnaround).
//  Simultaneous events and edge cases
//   - Request deassert mid-transaction is ignored; the transaction completes.
//   - MEM_AACK and MEM_ACK in the same cycle: AACK is honoured, the ACK is
//     ignored (protocol violation, flagged by assertion).
//   - Reset mid-burst: immediate return to IDLE; GNT drops asynchronously;
//     no DONE is generated.
//  Invariants
//   - IC_GNT and DC_GNT are never both 1.
//   - VAL and DONE only ever go to the granted side.
// STRUCTURE
//  - lmi_symbols.vh gains:
//    - MA_ST_IDLE/ADDR/DATA/DONE bit indices
//    - MA_ST_LAST
//    - MA_ST_RESET_VECT
//    - MA_OWNER_IC/DC encodings
//  - One sub-module, lmi_mem_arb_rr: 2-way round-robin pick plus write-stall
//    counter (combinational pick, registered pointer).
//  - One-hot state check under translate_off, matching the cache state machines.
// TESTING
//  1. IC_REQ=1, IC_BURST=1, IC_ADDR=0x0000_1234; ACK every cycle
//     -> MEM_ADDR=0x0000_1230; IC_VAL on 4 cycles with BEAT 0..3; IC_DONE pulses;
//        DC_* stay 0.
//  2. IC_REQ and DC_REQ rise in the same cycle after reset
//     -> IC served first, then DC.
//     Repeat the same tie -> DC served first.
//  3. DC_WR=1, DC_BURST=1, MEM_ACK gap of 3 cycles on beat 2
//     -> BEAT holds at 2; MEM_WDATA tracks DC_WDATA; DC_DONE after the 4th ACK.
//  4. MEM_BERR on beat 1 of an IC burst
//     -> IC_VAL only for beat 0; IC_DONE and ERR both pulse; next request is
//        granted 2 cycles later.
//  5. No ACK for 255 cycles -> ERR and DC_DONE; state back to IDLE.
//  6. RESET_D1_R_N low during DATA beat 2
//     -> GNT=0 immediately; after release, IC_REQ=1 is granted with BEAT=0.

Source files
------------

// File: rtl/lmi_mem_arb_pkg.sv
// Shared constants, state encodings and bus payload types for the memory-port arbiter.
package lmi_mem_arb_pkg;

  localparam int unsigned BEATS    = 4;
  localparam int unsigned CTR_W    = 2;
  localparam int unsigned MAX_WAIT = 255;
  localparam int unsigned WAIT_W   = 8;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned OFF_W    = CTR_W + 2;
  localparam int unsigned LINE_W   = ADDR_W - OFF_W;

  // One-hot state bit indices
  localparam int unsigned MA_ST_IDLE = 0;
  localparam int unsigned MA_ST_ADDR = 1;
  localparam int unsigned MA_ST_DATA = 2;
  localparam int unsigned MA_ST_DONE = 3;
  localparam int unsigned MA_ST_LAST = 3;
  localparam int unsigned MA_ST_W    = MA_ST_LAST + 1;

  localparam logic [MA_ST_W-1:0] MA_ST_RESET_VECT = MA_ST_W'(1 << MA_ST_IDLE);

  typedef enum logic [MA_ST_W-1:0] {
    ST_IDLE = MA_ST_W'(1 << MA_ST_IDLE),
    ST_ADDR = MA_ST_W'(1 << MA_ST_ADDR),
    ST_DATA = MA_ST_W'(1 << MA_ST_DATA),
    ST_DONE = MA_ST_W'(1 << MA_ST_DONE)
  } ma_state_e;

  typedef enum logic {
    MA_OWNER_IC = 1'b0,
    MA_OWNER_DC = 1'b1
  } ma_owner_e;

  // Address-phase payload latched at grant time
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic              burst;
  } mem_cmd_t;

  // Bursts go out line-aligned, single beats keep the exact word address
  function automatic logic [ADDR_W-1:0] ma_bus_addr(input logic [ADDR_W-1:0] a,
                                                    input logic burst);
    return burst ? {a[ADDR_W-1:OFF_W], OFF_W'(0)} : a;
  endfunction

endpackage

// File: rtl/lmi_mem_arb_rr.sv
// Two-way round-robin pick with a write-back stall escape for the D-cache.
module lmi_mem_arb_rr
  import lmi_mem_arb_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ic_req_i,
  input  logic              dc_req_i,
  input  logic              dc_wr_i,
  input  logic [LINE_W-1:0] dc_line_i,
  input  logic              arb_en_i,
  input  logic              done_en_i,
  output logic              pick_dc_c_o
);

  ma_owner_e         ptr_q, ptr_d;         // side with lower priority on the next tie
  ma_owner_e         win_q, win_d;         // winner of the transaction in flight
  logic              contested_q, contested_d;
  logic [1:0]        stall_q, stall_d;
  logic [LINE_W-1:0] stall_line_q, stall_line_d;
  logic              tie_c;
  logic              wr_boost_c;

  // Combinational pick: a write-back that lost twice on the same line jumps the pointer
  always_comb begin
    tie_c       = ic_req_i && dc_req_i;
    wr_boost_c  = dc_wr_i && (stall_q >= 2'd2) && (dc_line_i == stall_line_q);
    pick_dc_c_o = tie_c ? (wr_boost_c || (ptr_q == MA_OWNER_IC)) : dc_req_i;
  end

  // Pointer, contention and stall bookkeeping
  always_comb begin
    ptr_d        = ptr_q;
    win_d        = win_q;
    contested_d  = contested_q;
    stall_d      = stall_q;
    stall_line_d = stall_line_q;
    if (arb_en_i) begin
      contested_d = tie_c;
      win_d       = pick_dc_c_o ? MA_OWNER_DC : MA_OWNER_IC;
      if (pick_dc_c_o) begin
        stall_d = 2'd0;
      end else if (tie_c && dc_wr_i) begin
        if ((stall_q != 2'd0) && (dc_line_i == stall_line_q)) begin
          stall_d = (stall_q == 2'd3) ? 2'd3 : stall_q + 2'd1;
        end else begin
          stall_d      = 2'd1;
          stall_line_d = dc_line_i;
        end
      end
    end
    if (done_en_i && contested_q) begin
      ptr_d = win_q;
    end
  end

  // Arbitration state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q        <= MA_OWNER_DC;
      win_q        <= MA_OWNER_IC;
      contested_q  <= 1'b0;
      stall_q      <= 2'd0;
      stall_line_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      contested_q  <= contested_d;
      stall_q      <= stall_d;
      stall_line_q <= stall_line_d;
    end
  end

endmodule

// File: rtl/lmi_mem_arb.sv
// External memory port arbiter between the I-cache refill and D-cache engines.
module lmi_mem_arb
  import lmi_mem_arb_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  input  logic              ic_burst_i,
  input  logic              dc_req_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic              dc_wr_i,
  input  logic              dc_burst_i,
  input  logic [DATA_W-1:0] dc_wdata_i,
  output logic              ic_gnt_o,
  output logic              dc_gnt_o,
  output logic              ic_val_o,
  output logic              dc_val_o,
  output logic              ic_done_o,
  output logic              dc_done_o,
  output logic [CTR_W-1:0]  beat_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wr_o,
  output logic              mem_burst_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_aack_i,
  input  logic              mem_ack_i,
  input  logic              mem_berr_i
);

  ma_state_e         state_q, state_d;
  ma_owner_e         owner_q, owner_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic [CTR_W-1:0]  beat_q, beat_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              ic_gnt_q, ic_gnt_d, dc_gnt_q, dc_gnt_d;
  logic              ic_val_q, ic_val_d, dc_val_q, dc_val_d;
  logic              ic_done_q, ic_done_d, dc_done_q, dc_done_d;
  logic              err_q, err_d;
  logic              mem_req_q, mem_req_d;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              pick_dc_c;
  logic              arb_en_c;
  logic              done_en_c;
  logic [CTR_W-1:0]  cur_beat_c;
  logic              last_c;

  assign arb_en_c  = (state_q == ST_IDLE) && (ic_req_i || dc_req_i);
  assign done_en_c = (state_q == ST_DONE);

  lmi_mem_arb_rr u_rr (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .ic_req_i    (ic_req_i),
    .dc_req_i    (dc_req_i),
    .dc_wr_i     (dc_wr_i),
    .dc_line_i   (dc_addr_i[ADDR_W-1:OFF_W]),
    .arb_en_i    (arb_en_c),
    .done_en_i   (done_en_c),
    .pick_dc_c_o (pick_dc_c)
  );

  // The beat counter advances one cycle after each VAL so BEAT reads the beat that VAL reports
  always_comb begin
    cur_beat_c = beat_q + CTR_W'(ic_val_q | dc_val_q);
    last_c     = cmd_q.burst ? (cur_beat_c == CTR_W'(BEATS - 1)) : (cur_beat_c == '0);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cmd_d     = cmd_q;
    beat_d    = beat_q;
    wait_d    = wait_q;
    ic_gnt_d  = ic_gnt_q;
    dc_gnt_d  = dc_gnt_q;
    mem_req_d = mem_req_q;
    ic_val_d  = 1'b0;
    dc_val_d  = 1'b0;
    ic_done_d = 1'b0;
    dc_done_d = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ic_req_i || dc_req_i) begin
          if (pick_dc_c) begin
            owner_d   = MA_OWNER_DC;
            cmd_d     = '{addr: ma_bus_addr(dc_addr_i, dc_burst_i), wr: dc_wr_i, burst: dc_burst_i};
          end else begin
            owner_d   = MA_OWNER_IC;
            cmd_d     = '{addr: ma_bus_addr(ic_addr_i, ic_burst_i), wr: 1'b0, burst: ic_burst_i};
          end
          ic_gnt_d  = !pick_dc_c;
          dc_gnt_d  = pick_dc_c;
          mem_req_d = 1'b1;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (mem_aack_i) begin
          mem_req_d = 1'b0;
          beat_d    = '0;
          wait_d    = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        beat_d = cur_beat_c;
        if (mem_ack_i && !mem_berr_i) begin
          ic_val_d = (owner_q == MA_OWNER_IC);
          dc_val_d = (owner_q == MA_OWNER_DC);
          wait_d   = '0;
          if (last_c) begin
            ic_done_d = (owner_q == MA_OWNER_IC);
            dc_done_d = (owner_q == MA_OWNER_DC);
            state_d   = ST_DONE;
          end
        end else if (mem_ack_i || (wait_q == WAIT_W'(MAX_WAIT - 1))) begin
          err_d     = 1'b1;
          ic_done_d = (owner_q == MA_OWNER_IC);
          dc_done_d = (owner_q == MA_OWNER_DC);
          state_d   = ST_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_DONE: begin
        ic_gnt_d = 1'b0;
        dc_gnt_d = 1'b0;
        beat_d   = '0;
        state_d  = ST_IDLE;
      end
      default: begin
        ic_gnt_d  = 1'b0;
        dc_gnt_d  = 1'b0;
        mem_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops grants immediately
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      owner_q     <= MA_OWNER_IC;
      cmd_q       <= '0;
      beat_q      <= '0;
      wait_q      <= '0;
      ic_gnt_q    <= 1'b0;
      dc_gnt_q    <= 1'b0;
      ic_val_q    <= 1'b0;
      dc_val_q    <= 1'b0;
      ic_done_q   <= 1'b0;
      dc_done_q   <= 1'b0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cmd_q       <= cmd_d;
      beat_q      <= beat_d;
      wait_q      <= wait_d;
      ic_gnt_q    <= ic_gnt_d;
      dc_gnt_q    <= dc_gnt_d;
      ic_val_q    <= ic_val_d;
      dc_val_q    <= dc_val_d;
      ic_done_q   <= ic_done_d;
      dc_done_q   <= dc_done_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_wdata_q <= dc_wdata_i;
    end
  end

  assign ic_gnt_o    = ic_gnt_q;
  assign dc_gnt_o    = dc_gnt_q;
  assign ic_val_o    = ic_val_q;
  assign dc_val_o    = dc_val_q;
  assign ic_done_o   = ic_done_q;
  assign dc_done_o   = dc_done_q;
  assign beat_o      = beat_q;
  assign err_o       = err_q;
  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = cmd_q.addr;
  assign mem_wr_o    = cmd_q.wr;
  assign mem_burst_o = cmd_q.burst;
  assign mem_wdata_o = mem_wdata_q;

  // State encoding, grant exclusivity and address/data phase overlap checks
  a_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot(state_q));
  a_gnt_excl: assert property (@(posedge clk_i) disable iff (!rst_ni) !(ic_gnt_q && dc_gnt_q));
  a_aack_ack: assert property (@(posedge clk_i) disable iff (!rst_ni)
                               !((state_q == ST_ADDR) && mem_aack_i && mem_ack_i));

endmodule

// File: tb/tb_lmi_mem_arb.sv
// Directed bench for lmi_mem_arb: table of single transactions plus multi-cycle corner cases.
module tb_lmi_mem_arb;
  import lmi_mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ic_req, ic_burst, dc_req, dc_wr, dc_burst;
  logic [31:0] ic_addr, dc_addr, dc_wdata;
  logic        ic_gnt_o, dc_gnt_o, ic_val_o, dc_val_o, ic_done_o, dc_done_o;
  logic [1:0]  beat_o;
  logic        err_o, mem_req_o, mem_wr_o, mem_burst_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_aack, mem_ack, mem_berr;

  int n_cmp = 0;
  int n_err = 0;

  lmi_mem_arb dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .ic_req_i    (ic_req),
    .ic_addr_i   (ic_addr),
    .ic_burst_i  (ic_burst),
    .dc_req_i    (dc_req),
    .dc_addr_i   (dc_addr),
    .dc_wr_i     (dc_wr),
    .dc_burst_i  (dc_burst),
    .dc_wdata_i  (dc_wdata),
    .ic_gnt_o    (ic_gnt_o),
    .dc_gnt_o    (dc_gnt_o),
    .ic_val_o    (ic_val_o),
    .dc_val_o    (dc_val_o),
    .ic_done_o   (ic_done_o),
    .dc_done_o   (dc_done_o),
    .beat_o      (beat_o),
    .err_o       (err_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wr_o    (mem_wr_o),
    .mem_burst_o (mem_burst_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_aack_i  (mem_aack),
    .mem_ack_i   (mem_ack),
    .mem_berr_i  (mem_berr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_dc;
    logic [31:0] addr;
    bit          wr;
    bit          burst;
    logic [31:0] exp_addr;
    int          exp_vals;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit is_dc, input logic [31:0] addr, input bit wr, input bit burst);
    if (is_dc) begin
      dc_req = 1'b1; dc_addr = addr; dc_wr = wr; dc_burst = burst;
    end else begin
      ic_req = 1'b1; ic_addr = addr; ic_burst = burst;
    end
  endtask

  task automatic wait_mem_req(output int lat);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (mem_req_o) begin
        lat = i;
        break;
      end
    end
    check("mem_req seen", 32'(mem_req_o), 32'd1);
  endtask

  // One full transaction: address phase, then acks with optional gap / bus error
  task automatic xfer(input string tag, input bit is_dc, input logic [31:0] exp_addr,
                      input bit exp_wr, input bit exp_burst, input int exp_vals,
                      input bit exp_err, input int gap_at, input int gap_len,
                      input int berr_at, output int lat, output int ncyc);
    int          acks;
    int          vals;
    int          gap_left;
    bit          done_seen;
    bit          acked;
    logic [31:0] wd;
    acks = 0; vals = 0; gap_left = gap_len; done_seen = 0; ncyc = 0;
    wait_mem_req(lat);
    if (lat == 0) return;
    check({tag, " gnt"}, {30'd0, ic_gnt_o, dc_gnt_o}, is_dc ? 32'd1 : 32'd2);
    check({tag, " addr"}, mem_addr_o, exp_addr);
    check({tag, " wr/burst"}, {30'd0, mem_wr_o, mem_burst_o}, {30'd0, exp_wr, exp_burst});
    check({tag, " beat at grant"}, 32'(beat_o), 32'd0);
    mem_aack = 1'b1;
    @(negedge clk);
    mem_aack = 1'b0;
    check({tag, " mem_req drop"}, 32'(mem_req_o), 32'd0);
    for (int c = 0; c < 300 && !done_seen; c++) begin
      acked = 0;
      if (gap_at == acks && gap_left > 0) begin
        gap_left--;
      end else begin
        mem_ack  = 1'b1;
        mem_berr = (acks == berr_at);
        acked    = 1;
        acks++;
      end
      wd       = $urandom;
      dc_wdata = wd;
      @(negedge clk);
      mem_ack  = 1'b0;
      mem_berr = 1'b0;
      ncyc++;
      check({tag, " wdata"}, mem_wdata_o, wd);
      if (!acked && acks == gap_at) check({tag, " beat hold"}, 32'(beat_o), 32'(gap_at));
      if (ic_val_o || dc_val_o) begin
        check({tag, " val side"}, {30'd0, ic_val_o, dc_val_o}, is_dc ? 32'd1 : 32'd2);
        check({tag, " val beat"}, 32'(beat_o), 32'(vals));
        vals++;
      end
      if (ic_done_o || dc_done_o) begin
        done_seen = 1;
        check({tag, " done side"}, {30'd0, ic_done_o, dc_done_o}, is_dc ? 32'd1 : 32'd2);
        check({tag, " err"}, 32'(err_o), 32'(exp_err));
        if (is_dc) dc_req = 1'b0; else ic_req = 1'b0;
      end
    end
    check({tag, " done seen"}, 32'(done_seen), 32'd1);
    check({tag, " val count"}, 32'(vals), 32'(exp_vals));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ncyc;
    rst_n = 1'b0;
    ic_req = 0; ic_burst = 0; ic_addr = '0;
    dc_req = 0; dc_wr = 0; dc_burst = 0; dc_addr = '0; dc_wdata = '0;
    mem_aack = 0; mem_ack = 0; mem_berr = 0;

    vecs[0] = '{is_dc: 0, addr: 32'h0000_1234, wr: 0, burst: 1, exp_addr: 32'h0000_1230, exp_vals: 4};
    vecs[1] = '{is_dc: 0, addr: 32'h0000_1234, wr: 0, burst: 0, exp_addr: 32'h0000_1234, exp_vals: 1};
    vecs[2] = '{is_dc: 1, addr: 32'h8000_003C, wr: 0, burst: 1, exp_addr: 32'h8000_0030, exp_vals: 4};
    vecs[3] = '{is_dc: 1, addr: 32'h4000_0008, wr: 1, burst: 0, exp_addr: 32'h4000_0008, exp_vals: 1};
    vecs[4] = '{is_dc: 1, addr: 32'hFFFF_FFFC, wr: 1, burst: 1, exp_addr: 32'hFFFF_FFF0, exp_vals: 4};

    repeat (2) @(negedge clk);
    check("reset ctrl", {18'd0, ic_gnt_o, dc_gnt_o, ic_val_o, dc_val_o, ic_done_o, dc_done_o,
                         beat_o, err_o, mem_req_o, mem_wr_o, mem_burst_o}, 32'd0);
    check("reset mem_addr", mem_addr_o, 32'd0);
    check("reset mem_wdata", mem_wdata_o, 32'd0);
    rst_n = 1'b1;

    // Isolated transactions from the table
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(vecs[i].is_dc, vecs[i].addr, vecs[i].wr, vecs[i].burst);
      xfer($sformatf("vec%0d", i), vecs[i].is_dc, vecs[i].exp_addr, vecs[i].wr, vecs[i].burst,
           vecs[i].exp_vals, 0, -1, 0, -1, lat, ncyc);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd1);
    end

    // Tie: I-cache first, then D-cache; the repeated tie goes to the D-cache
    @(negedge clk);
    drive(0, 32'h0000_2000, 0, 1);
    drive(1, 32'h0000_3004, 0, 0);
    xfer("tie1 ic", 0, 32'h0000_2000, 0, 1, 4, 0, -1, 0, -1, lat, ncyc);
    check("tie1 ic latency", 32'(lat), 32'd1);
    xfer("tie1 dc", 1, 32'h0000_3004, 0, 0, 1, 0, -1, 0, -1, lat, ncyc);
    check("tie1 dc turnaround", 32'(lat), 32'd2);
    @(negedge clk);
    drive(0, 32'h0000_2000, 0, 1);
    drive(1, 32'h0000_3004, 0, 0);
    xfer("tie2 dc", 1, 32'h0000_3004, 0, 0, 1, 0, -1, 0, -1, lat, ncyc);
    check("tie2 dc latency", 32'(lat), 32'd1);
    xfer("tie2 ic", 0, 32'h0000_2000, 0, 1, 4, 0, -1, 0, -1, lat, ncyc);
    check("tie2 ic turnaround", 32'(lat), 32'd2);

    // Write-back burst with a 3-cycle ack gap on beat 2
    @(negedge clk);
    drive(1, 32'h1000_0044, 1, 1);
    xfer("wr gap", 1, 32'h1000_0040, 1, 1, 4, 0, 2, 3, -1, lat, ncyc);

    // Bus error on beat 1 of an I-cache burst, then the next request
    @(negedge clk);
    drive(0, 32'h0000_5008, 0, 1);
    xfer("berr", 0, 32'h0000_5000, 0, 1, 1, 1, -1, 0, 1, lat, ncyc);
    drive(0, 32'h0000_6000, 0, 0);
    xfer("after berr", 0, 32'h0000_6000, 0, 0, 1, 0, -1, 0, -1, lat, ncyc);
    check("after berr turnaround", 32'(lat), 32'd2);

    // No ack at all: timeout after 255 data-phase cycles
    @(negedge clk);
    drive(1, 32'h2000_0010, 0, 0);
    xfer("timeout", 1, 32'h2000_0010, 0, 0, 0, 1, 0, 1000, -1, lat, ncyc);
    check("timeout cycles", 32'(ncyc), 32'd255);
    drive(0, 32'h0000_7000, 0, 0);
    xfer("after timeout", 0, 32'h0000_7000, 0, 0, 1, 0, -1, 0, -1, lat, ncyc);
    check("after timeout turnaround", 32'(lat), 32'd2);

    // Reset while waiting on beat 2 of an I-cache burst
    @(negedge clk);
    drive(0, 32'h0000_8000, 0, 1);
    wait_mem_req(lat);
    mem_aack = 1'b1;
    @(negedge clk);
    mem_aack = 1'b0;
    mem_ack  = 1'b1;
    repeat (2) @(negedge clk);
    mem_ack  = 1'b0;
    check("pre-reset beat", 32'(beat_o), 32'd1);
    check("pre-reset gnt", 32'(ic_gnt_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async reset gnt", {30'd0, ic_gnt_o, dc_gnt_o}, 32'd0);
    check("async reset req/beat", {29'd0, mem_req_o, beat_o}, 32'd0);
    @(negedge clk);
    check("reset no done", {29'd0, ic_done_o, dc_done_o, err_o}, 32'd0);
    rst_n = 1'b1;
    xfer("after reset", 0, 32'h0000_8000, 0, 1, 4, 0, -1, 0, -1, lat, ncyc);
    check("after reset latency", 32'(lat), 32'd1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
